// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: state encoding, legal
// WIDTH range and the step-counter width helper.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // The counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell from the arithmetic library.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_add.sv
// Parametrised N-bit ripple-carry adder built as a chain of fa cells.
module rca_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa u_fa (
            .a (x[i]),
            .b (y[i]),
            .ci(c[i]),
            .s (sum[i]),
            .co(c[i+1])
        );
    end

    assign cout = c[N];

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: sign-magnitude core, WIDTH cycles per product,
// valid/ready on both sides, registered 2*WIDTH-bit result.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = cnt_w(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("seq_mult: WIDTH out of range");
    end

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, mplier;
    logic [2*WIDTH-1:0]   acc, acc_step, neg_sum;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic [WIDTH:0]       add_sum;
    logic                 add_cout_unused;
    logic                 neg_cout_unused;

    // Magnitude of a captured operand; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
        return (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    rca_add #(.N(WIDTH + 1)) u_acc_add (
        .x   ({1'b0, acc[2*WIDTH-1:WIDTH]}),
        .y   ({1'b0, mcand}),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout_unused)
    );

    // Upper half absorbs the conditional add, then the whole accumulator shifts right.
    assign acc_step = {(mplier[0] ? add_sum : {1'b0, acc[2*WIDTH-1:WIDTH]}), acc[WIDTH-1:1]};

    rca_add #(.N(2 * WIDTH)) u_neg (
        .x   (~acc_step),
        .y   ('0),
        .cin (1'b1),
        .sum (neg_sum),
        .cout(neg_cout_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mag(a, signed_mode);
                        mplier <= mag(b, signed_mode);
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt    <= CW'(WIDTH);
                        acc    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Negating a zero magnitude yields zero, so no -0 can appear.
                    if (cnt == CW'(1)) p <= neg ? neg_sum : acc_step;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier; next-generation replacement for the fixed 4x4 combinational array multiplier in the arithmetic library. It accepts one operand pair per transaction over a valid/ready handshake and computes over WIDTH cycles. It supports unsigned or two's-complement signed operation, selected per transaction. It returns a registered 2*WIDTH-bit product with output backpressure, and sits between operand-issue logic and the accumulator datapath.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = a, b and product are two's complement; 0 = unsigned.
- out_valid  out  1  product valid; high only in DONE.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  product.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture operands and go to CALC.
  - Captured operands: |a|, |b| (magnitudes when signed_mode=1, raw otherwise), sign flag neg = signed_mode & (a[MSB]^b[MSB]), step counter = WIDTH, accumulator = 0.
- CALC, one step per cycle:
  - If multiplier LSB=1, add the multiplicand into the upper WIDTH+1 bits of the accumulator via the ripple adder.
  - Shift the accumulator and multiplier right by 1, decrement the counter.
  - After the WIDTH-th step, go to DONE.
  - On the DONE transition, p = neg ? two's-complement negate(acc) : acc.
- DONE:
  - out_valid=1; p held stable.
  - On out_valid&&out_ready, go to IDLE.
  - No same-cycle re-accept; in_ready rises the following cycle.
- Arithmetic:
  - Magnitude of most-negative input (-2^(WIDTH-1)) is 2^(WIDTH-1) and is representable as unsigned WIDTH bits.
  - Product always fits in 2*WIDTH bits; no overflow flag.
  - Either operand zero gives p=0; neg is ignored (no -0).
- in_valid, a, b and signed_mode are ignored outside IDLE; operands are used only as captured at accept.
- out_ready is ignored outside DONE.
- Reset (any time, including mid-CALC or DONE):
  - state=IDLE, p=0, out_valid=0, in_ready=1 once rst deasserts.
  - Accumulator, counter and operand registers cleared.
  - An in-flight operation is discarded with no output.

## Timing
- Accept edge E0; CALC steps on edges E1..E(WIDTH).
- out_valid=1 after edge E(WIDTH), i.e. WIDTH cycles after the accept edge.
- Minimum transaction period: WIDTH+2 cycles (accept, WIDTH CALC cycles, one DONE cycle with out_ready=1), then IDLE again.
- in_ready and out_valid are pure state decodes, registered-state driven; no combinational path from in_valid or out_ready.
- p changes only on the CALC->DONE edge and on reset.

## Structure
- Shared package mult_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - WIDTH legality bounds;
  - the counter-width function clog2(WIDTH+1).
- One sub-module, rca_add: parametrised N-bit ripple-carry adder built from the existing fa cell, with carry-out. It is instantiated once at WIDTH+1 bits for the accumulate step.
- Negation reuses a second rca_add instance, computing ~acc + 1.

## Test plan
- WIDTH=4, unsigned, a=15, b=15, out_ready=1 -> out_valid 4 cycles after accept, p=8'hE1 (225), in_ready high the cycle after hand-off.
- WIDTH=4, signed: a=-8, b=-8 -> p=8'h40. Then a=-3, b=5 -> p=8'hF1 (-15). Then a=0, b=-7 -> p=8'h00.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing a/b -> p and out_valid stable, in_ready=0, no new accept. Then out_ready=1 -> single hand-off.
- Reset mid-operation: assert rst on the 2nd CALC cycle -> out_valid=0, p=0 immediately (asynchronous). After release, in_ready=1 and no stale product appears.
- WIDTH=8: unsigned 255*255 -> p=16'hFE01, latency 8 cycles. Then 2000 random operand/mode transactions against a behavioural reference model, with random in_valid/out_ready gaps -> zero mismatches.
- WIDTH=4 exhaustive: all 256 pairs × both modes back-to-back -> every product matches the model, each transaction period exactly WIDTH+2 cycles with out_ready tied high.
